// File: rtl/ghostbus_host_if.sv
// ============================================================================
// Module   : ghostbus_host_if
// Brief    : Command/response stream and ghostbus strobe bundle for the host.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface ghostbus_host_if #(
    parameter int AW = 24,
    parameter int DW = 32
);
    // command stream
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [7:0]    req_len;
    // response stream
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_last;
    // ghostbus
    logic [AW-1:0] gb_addr;
    logic [DW-1:0] gb_wdata;
    logic          gb_wen;
    logic          gb_rstb;
    logic [DW-1:0] gb_rdata;

    // host (bus initiator) side
    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_len,
        input  rsp_ready, gb_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_last,
        output gb_addr, gb_wdata, gb_wen, gb_rstb
    );

    // command source / bus target side
    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_len,
        output rsp_ready, gb_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_last,
        input  gb_addr, gb_wdata, gb_wen, gb_rstb
    );
endinterface

`default_nettype wire

// File: rtl/ghostbus_host.sv
// ============================================================================
// Module   : ghostbus_host
// Brief    : Ghostbus initiator; valid/ready commands to single-cycle strobes.
//            Define GHOSTBUS_HOST_BURST_EN for address-incrementing bursts.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ghostbus_host #(
    parameter int AW         = 24,
    parameter int DW         = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    ghostbus_host_if.master bus,
    output logic            busy
);

    localparam logic [3:0] c_rd_latency = 4'(RD_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RWAIT = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_run;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic [3:0]    r_lat;

    logic          w_req_ready;
    logic          w_req_hs;
    logic          w_rsp_valid;
    logic          w_rsp_hs;
    logic          w_wen;
    logic          w_rstb;
    logic          w_last;

    // ------------------------------------------------------------------
    // Burst beat counter
    // ------------------------------------------------------------------
`ifdef GHOSTBUS_HOST_BURST_EN
    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (w_req_hs) begin
            r_cnt <= bus.req_len;
        end else if (w_rsp_hs && !w_last) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign w_last = (r_cnt == 8'd0);
`else
    logic w_unused_len;

    assign w_unused_len = ^bus.req_len;
    assign w_last       = 1'b1;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and strobe/handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        w_wen       = 1'b0;
        w_rstb      = 1'b0;

        case (r_state)
            S_IDLE: begin
                // r_run keeps ready low until the first edge after reset release
                w_req_ready = r_run;
                if (r_run && bus.req_valid) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_wen       = r_we;
                w_rstb      = ~r_we;
                w_state_nxt = r_we ? S_RESP : S_RWAIT;
            end
            S_RWAIT: begin
                if (r_lat == 4'd1) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_state_nxt = w_last ? S_IDLE : S_ISSUE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_req_hs = w_req_ready & bus.req_valid;
    assign w_rsp_hs = w_rsp_valid & bus.rsp_ready;

    // ------------------------------------------------------------------
    // Datapath: command latch, read latency counter, read data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_lat   <= 4'd0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_req_hs) begin
                        r_we    <= bus.req_we;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                    end
                end
                S_ISSUE: begin
                    if (r_we) begin
                        r_rdata <= '0;
                    end else begin
                        r_lat <= c_rd_latency;
                    end
                end
                S_RWAIT: begin
                    r_lat <= r_lat - 4'd1;
                    if (r_lat == 4'd1) begin
                        r_rdata <= bus.gb_rdata;
                    end
                end
                S_RESP: begin
                    // address wraps naturally at AW bits
                    if (w_rsp_hs && !w_last) begin
                        r_addr <= r_addr + AW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs; r_addr/r_wdata only change on entry to ISSUE, so they
    // serve directly as the held bus address and data.
    // ------------------------------------------------------------------
    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_last  = w_rsp_valid & w_last;
    assign bus.gb_addr   = r_addr;
    assign bus.gb_wdata  = r_wdata;
    assign bus.gb_wen    = w_wen;
    assign bus.gb_rstb   = w_rstb;
    assign busy          = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ghostbus_host.sv
// ============================================================================
// Module   : tb_ghostbus_host
// Brief    : Directed self-checking bench for ghostbus_host (RD_LATENCY = 2).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ghostbus_host;

    localparam int AW = 24;
    localparam int DW = 32;
    localparam int RDL = 2;
`ifdef GHOSTBUS_HOST_BURST_EN
    localparam int BURST = 1;
`else
    localparam int BURST = 0;
`endif
    localparam int NBEATS = BURST ? 4 : 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    int n_checks = 0;
    int n_errors = 0;

    ghostbus_host_if #(.AW(AW), .DW(DW)) bif ();

    ghostbus_host #(.AW(AW), .DW(DW), .RD_LATENCY(RDL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.master),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // bus target model: data valid RDL cycles after the strobe, garbage otherwise
    logic [1:0]    p_v = 2'b00;
    logic [AW-1:0] p_a0 = '0;
    logic [AW-1:0] p_a1 = '0;
    logic [DW-1:0] cyc = '0;
    int            n_wen = 0;
    int            n_rstb = 0;
    int            n_both = 0;
    logic [AW-1:0] rd_log[$];

    function automatic logic [DW-1:0] rdval(input logic [AW-1:0] a);
        return (a == 24'h000020) ? 32'hDEADBEEF : {8'hC3, a};
    endfunction

    always @(posedge clk) begin
        p_v  <= {p_v[0], bif.gb_rstb};
        p_a0 <= bif.gb_addr;
        p_a1 <= p_a0;
        cyc  <= cyc + 32'd1;
        if (bif.gb_wen) n_wen <= n_wen + 1;
        if (bif.gb_rstb) begin
            n_rstb <= n_rstb + 1;
            rd_log.push_back(bif.gb_addr);
        end
        if (bif.gb_wen && bif.gb_rstb) n_both <= n_both + 1;
    end

    assign bif.gb_rdata = p_v[1] ? rdval(p_a1) : (32'hBADBAD00 ^ cyc);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [7:0] len);
        bif.req_valid = 1'b1;
        bif.req_we    = we;
        bif.req_addr  = a;
        bif.req_wdata = d;
        bif.req_len   = len;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] got_d[4];
        logic          got_l[4];
        logic [AW-1:0] exp_a[4];
        logic [DW-1:0] held;
        int            nr;
        int            start;
        int            w0;
        int            r0;

        exp_a = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
        bif.req_valid = 1'b0;
        bif.req_we    = 1'b0;
        bif.req_addr  = '0;
        bif.req_wdata = '0;
        bif.req_len   = 8'd0;
        bif.rsp_ready = 1'b0;

        // ---------------- reset ----------------
        repeat (5) tick();
        check("rst_req_ready", bif.req_ready, 0);
        check("rst_rsp_valid", bif.rsp_valid, 0);
        check("rst_gb_wen",    bif.gb_wen, 0);
        check("rst_gb_rstb",   bif.gb_rstb, 0);
        check("rst_gb_addr",   bif.gb_addr, 0);
        check("rst_busy",      busy, 0);
        check("rst_rdata",     bif.rsp_rdata, 0);
        rst_n = 1'b1;
        tick();
        check("rel_req_ready", bif.req_ready, 1);

        // ---------------- single write ----------------
        send(1'b1, 24'h000010, 32'h00000042, 8'd0);
        tick();                                   // E0+1
        bif.req_valid = 1'b0;
        check("wr_wen",       bif.gb_wen, 1);
        check("wr_rstb",      bif.gb_rstb, 0);
        check("wr_addr",      bif.gb_addr, 24'h000010);
        check("wr_wdata",     bif.gb_wdata, 32'h42);
        check("wr_rsp_early", bif.rsp_valid, 0);
        check("wr_busy",      busy, 1);
        tick();                                   // E0+2
        check("wr_wen_pulse", bif.gb_wen, 0);
        check("wr_rsp_valid", bif.rsp_valid, 1);
        check("wr_rsp_rdata", bif.rsp_rdata, 0);
        check("wr_rsp_last",  bif.rsp_last, 1);
        bif.rsp_ready = 1'b1;
        tick();
        bif.rsp_ready = 1'b0;
        check("wr_done_valid", bif.rsp_valid, 0);
        check("wr_done_busy",  busy, 0);
        check("wr_wen_count",  n_wen, 1);

        // ---------------- single read ----------------
        send(1'b0, 24'h000020, 32'h0, 8'd0);
        tick();                                   // E0+1
        bif.req_valid = 1'b0;
        check("rd_rstb",    bif.gb_rstb, 1);
        check("rd_addr",    bif.gb_addr, 24'h000020);
        tick();                                   // E0+2
        check("rd_rstb_pulse", bif.gb_rstb, 0);
        check("rd_valid_e2",   bif.rsp_valid, 0);
        tick();                                   // E0+3
        check("rd_valid_e3",   bif.rsp_valid, 0);
        tick();                                   // E0+4
        check("rd_valid_e4",   bif.rsp_valid, 1);
        check("rd_rdata",      bif.rsp_rdata, 32'hDEADBEEF);
        check("rd_last",       bif.rsp_last, 1);
        repeat (2) tick();
        check("rd_rdata_hold", bif.rsp_rdata, 32'hDEADBEEF);
        bif.rsp_ready = 1'b1;
        tick();
        bif.rsp_ready = 1'b0;
        check("rd_done_busy", busy, 0);

        // ---------------- burst read across address wrap ----------------
        start = rd_log.size();
        send(1'b0, 24'hFFFFFE, 32'h0, 8'd3);
        bif.rsp_ready = 1'b1;
        tick();
        bif.req_valid = 1'b0;
        nr = 0;
        for (int i = 0; i < 40 && nr < NBEATS; i++) begin
            if (bif.rsp_valid) begin
                got_d[nr] = bif.rsp_rdata;
                got_l[nr] = bif.rsp_last;
                nr++;
            end
            tick();
        end
        repeat (6) tick();
        check("bu_nrsp",   nr, NBEATS);
        check("bu_nrstb",  rd_log.size() - start, NBEATS);
        check("bu_busy",   busy, 0);
        for (int k = 0; k < NBEATS; k++) begin
            check($sformatf("bu_addr%0d", k), rd_log[start + k], exp_a[k]);
            check($sformatf("bu_data%0d", k), got_d[k], {8'hC3, exp_a[k]});
            check($sformatf("bu_last%0d", k), got_l[k], (k == NBEATS - 1) ? 1 : 0);
        end
        bif.rsp_ready = 1'b0;

        // ---------------- backpressure on a 2-beat write ----------------
        send(1'b1, 24'h000100, 32'h00000077, 8'd1);
        tick();                                   // ISSUE beat 0
        check("bp_wen0", bif.gb_wen, 1);
        send(1'b0, 24'h000030, 32'h0, 8'd0);      // competing command while busy
        tick();                                   // RESP beat 0
        w0 = n_wen;
        held = bif.rsp_rdata;
        for (int i = 0; i < 6; i++) begin
            check("bp_valid",  bif.rsp_valid, 1);
            check("bp_last",   bif.rsp_last, BURST ? 0 : 1);
            check("bp_rdata",  bif.rsp_rdata, held);
            check("bp_ready",  bif.req_ready, 0);
            check("bp_nowen",  bif.gb_wen, 0);
            tick();
        end
        bif.req_valid = 1'b0;
        check("bp_wen_count", n_wen, w0);
        bif.rsp_ready = 1'b1;
        tick();                                   // after beat 0 handshake
        check("bp_wen1",  bif.gb_wen, BURST);
        check("bp_addr1", bif.gb_addr, BURST ? 24'h000101 : 24'h000100);
        check("bp_busy1", busy, BURST);
        tick();
        check("bp_valid1", bif.rsp_valid, BURST);
        check("bp_last1",  bif.rsp_last, BURST);
        tick();
        bif.rsp_ready = 1'b0;
        check("bp_idle",  busy, 0);
        check("bp_total_wen", n_wen, w0 + BURST);

        // ---------------- reset during RWAIT ----------------
        r0 = n_rstb;
        send(1'b0, 24'h000040, 32'h0, 8'd3);
        bif.rsp_ready = 1'b1;
        tick();                                   // ISSUE
        bif.req_valid = 1'b0;
        check("mr_rstb", bif.gb_rstb, 1);
        tick();                                   // RWAIT
        check("mr_in_rwait", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mr_busy",      busy, 0);
        check("mr_rsp_valid", bif.rsp_valid, 0);
        check("mr_req_ready", bif.req_ready, 0);
        check("mr_gb_addr",   bif.gb_addr, 0);
        repeat (3) tick();
        check("mr_no_rsp", bif.rsp_valid, 0);
        rst_n = 1'b1;
        tick();
        check("mr_ready", bif.req_ready, 1);
        repeat (3) tick();
        check("mr_no_strobe", n_rstb, r0 + 1);

        send(1'b0, 24'h000020, 32'h0, 8'd0);
        tick();
        bif.req_valid = 1'b0;
        check("pr_rstb", bif.gb_rstb, 1);
        repeat (3) tick();                        // E0+4
        check("pr_valid", bif.rsp_valid, 1);
        check("pr_rdata", bif.rsp_rdata, 32'hDEADBEEF);
        tick();
        bif.rsp_ready = 1'b0;
        check("pr_idle", busy, 0);

        check("strobes_exclusive", n_both, 0);
        check("total_rstb", n_rstb, 3 + NBEATS);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ghostbus_host.md
# ghostbus_host

Ghostbus initiator: turns a valid/ready command stream (from a UART/Ethernet bridge or test sequencer) into single-clock ghostbus strobes (addr, wdata, wen, rstb) and returns read data.
- Sits at the root of the bus tree and drives the `gb_*` ports of the design's top module.
- Read data is sampled a fixed, parameterised number of cycles after the read strobe.
- Optional address-incrementing bursts let one command cover a block of CSRs.

## Interface
- `AW`, 24: bus address width.
- `DW`, 32: bus data width.
- `RD_LATENCY`, 2: cycles from `gb_rstb` to valid `gb_rdata`; legal range 1..15.
- `clk`  in  1  ghostbus clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  command valid.
- `req_ready`  out  1  command accepted when both high.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  AW  start address.
- `req_wdata`  in  DW  write data; the same value is used for every beat of a burst.
- `req_len`  in  8  beats minus one; used only with the burst feature.
- `rsp_valid`  out  1  response valid; held until accepted.
- `rsp_ready`  in  1  response accepted when both high.
- `rsp_rdata`  out  DW  read data; 0 for writes.
- `rsp_last`  out  1  final beat of the command.
- `busy`  out  1  high in any state other than IDLE.
- `gb_addr`  out  AW  bus address.
- `gb_wdata`  out  DW  bus write data.
- `gb_wen`  out  1  write strobe; a single-cycle pulse.
- `gb_rstb`  out  1  read strobe; a single-cycle pulse.
- `gb_rdata`  in  DW  bus read data.

## Operation
- State machine: IDLE, ISSUE, RWAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On handshake: latch we, addr, wdata, and beat count (`req_len`, or 0 without the burst feature); go to ISSUE.
- ISSUE (one cycle):
  - Drive `gb_addr`=current addr and `gb_wdata`=wdata.
  - Write: `gb_wen`=1; rdata register cleared to 0; go to RESP.
  - Read: `gb_rstb`=1; load latency counter with `RD_LATENCY`; go to RWAIT.
- RWAIT:
  - Decrement the counter each cycle.
  - In the cycle where the counter reads 1, capture `gb_rdata` into the rdata register; go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_last`=1 when the beat count is 0.
  - On handshake with beats remaining: addr += 1 (mod 2^AW; wraps from all-ones to 0), count -= 1, go to ISSUE.
  - On handshake with no beats remaining: go to IDLE.
- `gb_addr` and `gb_wdata` are registered and hold their last value outside ISSUE. `gb_wen` and `gb_rstb` are never high together and never high outside ISSUE.
- Exactly one bus access is outstanding at a time. The next beat is not issued until the previous response is accepted.
- A `req_valid` arriving while busy waits; `req_ready`=0 until IDLE.
- Reset values: `req_ready`=0 while `rst_n` is low, then 1 in IDLE. `rsp_valid`, `rsp_last`, `busy`, `gb_wen`, `gb_rstb` are 0. `gb_addr`, `gb_wdata`, `rsp_rdata` are 0.
- Reset mid-operation:
  - Asynchronous; all outputs go to their reset values immediately, including a strobe in flight.
  - Any pending beats are discarded and no response is produced.
  - Returns to IDLE on the first edge after release.

## Timing
- Request handshake at edge E0: strobe high in cycle E0+1.
- Write: `rsp_valid` high from cycle E0+2.
- Read:
  - `gb_rdata` is captured at the end of cycle E0+1+`RD_LATENCY`.
  - `rsp_valid` high from cycle E0+2+`RD_LATENCY`.
- Burst: each further beat's strobe comes one cycle after the response handshake of the previous beat.
- Throughput with `rsp_ready` tied high:
  - Writes: one beat per 2 cycles.
  - Reads: one beat per `RD_LATENCY`+2 cycles.
- `rsp_rdata` is stable while `rsp_valid` is high.

## Configuration
- `GHOSTBUS_HOST_BURST_EN` defined:
  - `req_len` honoured; a command produces `req_len`+1 beats at incrementing addresses.
  - `rsp_last` is asserted only on the final beat.
- Not defined:
  - `req_len` ignored and the burst counter is not built.
  - Every command is one beat, with `rsp_last`=1 on every response.

## Test plan
- Reset: hold `rst_n` low 5 cycles → all strobes and `rsp_valid` 0; `gb_addr`=0; `req_ready`=1 on the first cycle after release.
- Write `addr`=0x000010, `wdata`=0x42 → `gb_wen` high exactly 1 cycle with `gb_addr`=0x10, `gb_wdata`=0x42; `rsp_valid` at E0+2 with `rsp_rdata`=0, `rsp_last`=1.
- Read with `RD_LATENCY`=2, model returning 0xDEADBEEF 2 cycles after `gb_rstb` → `rsp_valid` at E0+4 with 0xDEADBEEF; a garbage value on `gb_rdata` in other cycles is not captured.
- Burst read (macro on) `addr`=0xFFFFFE, `len`=3 → `gb_rstb` at addresses 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001; 4 responses, `rsp_last` on the 4th only.
- Backpressure: `rsp_ready` low for 6 cycles during a 2-beat burst → response held stable, second strobe only after the handshake, no extra strobes; `req_valid` during busy is not accepted.
- Drop `rst_n` during RWAIT of a burst → no response; `busy`=0 immediately; a new read after release completes normally.
